// File: rtl/weight_stream_mem.sv
// Weight store: streamed load, LANES-wide backpressured readout.
// FSM sequences load/read with finish and error pulses.
module weight_stream_mem #(
    parameter int ELEM_W = 32,
    parameter int DEPTH  = 64,
    parameter int LANES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic                    load_valid,
    input  logic [ELEM_W-1:0]       load_data,
    output logic                    load_ready,
    input  logic                    read_start,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ELEM_W-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    finish,
    output logic                    err
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NBEATS = DEPTH / LANES;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

    state_t                   state;
    logic [ELEM_W-1:0]        mem [DEPTH];
    logic [ADDR_W-1:0]        wptr;
    logic [BEAT_W-1:0]        beat;
    logic [BEAT_W-1:0]        nbeat;
    logic [LANES*ELEM_W-1:0]  nbeat_data;
    logic                     accept_w;
    logic                     accept_b;
    logic                     start_err;

    assign accept_w  = load_valid && load_ready;
    assign accept_b  = out_valid && out_ready;
    assign nbeat     = (state == IDLE) ? '0 : beat + 1'b1;
    assign start_err = (state != IDLE) ? (load_start || read_start)
                                       : (load_start && read_start);

    // Gather the beat that will be presented next (beat 0 when starting)
    always_comb begin
        nbeat_data = '0;
        for (int k = 0; k < LANES; k++) begin
            nbeat_data[k*ELEM_W +: ELEM_W] =
                mem[ADDR_W'(nbeat) * ADDR_W'(LANES) + ADDR_W'(k)];
        end
    end

    // Storage is intentionally not reset so weights survive rst
    always_ff @(posedge clk) begin
        if (!rst && accept_w) begin
            mem[wptr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wptr       <= '0;
            beat       <= '0;
            load_ready <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            finish     <= 1'b0;
            err        <= 1'b0;
        end else begin
            finish <= 1'b0;
            err    <= start_err;
            unique case (state)
                IDLE: begin
                    if (load_start) begin
                        state      <= LOAD;
                        wptr       <= '0;
                        load_ready <= 1'b1;
                        busy       <= 1'b1;
                    end else if (read_start) begin
                        state     <= READ;
                        beat      <= '0;
                        out_valid <= 1'b1;
                        out_last  <= (NBEATS == 1);
                        out_data  <= nbeat_data;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept_w) begin
                        wptr <= wptr + 1'b1;
                        if (wptr == LAST_ADDR) begin
                            state      <= IDLE;
                            load_ready <= 1'b0;
                            busy       <= 1'b0;
                            finish     <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (accept_b) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            finish    <= 1'b1;
                        end else begin
                            beat     <= nbeat;
                            out_data <= nbeat_data;
                            out_last <= (nbeat == LAST_BEAT);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_stream_mem.sv
// Scoreboard bench for weight_stream_mem: directed loads and readouts,
// beats checked by a negedge monitor against a queue of expected beats.
module tb_weight_stream_mem;
    localparam int ELEM_W = 32;
    localparam int DEPTH  = 64;
    localparam int LANES  = 4;
    localparam int NBEATS = DEPTH / LANES;
    localparam int DW     = ELEM_W * LANES;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [ELEM_W-1:0] load_data = '0;
    logic              load_ready;
    logic              read_start = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              busy;
    logic              finish;
    logic              err;

    weight_stream_mem #(.ELEM_W(ELEM_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .read_start (read_start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .finish     (finish),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t             sb[$];
    logic [ELEM_W-1:0] model [DEPTH];
    int                checks = 0;
    int                errors = 0;
    logic              stalled = 1'b0;
    logic [DW-1:0]     held = '0;

    task automatic chk(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read();
        beat_t e;
        for (int b = 0; b < NBEATS; b++) begin
            e.data = '0;
            for (int k = 0; k < LANES; k++)
                e.data[k*ELEM_W +: ELEM_W] = model[b*LANES + k];
            e.last = (b == NBEATS - 1);
            sb.push_back(e);
        end
    endtask

    task automatic do_load(input logic [ELEM_W-1:0] base, input bit incr,
                           input bit gap, input bit started, input int nwords);
        int  acc;
        int  cyc;
        bit  v;
        if (!started) begin
            load_start = 1'b1;
            tick();
            load_start = 1'b0;
        end
        acc = 0;
        cyc = 0;
        while (acc < nwords && cyc < 400) begin
            v = !(gap && (cyc % 2 == 1));
            load_valid = v;
            load_data  = incr ? base + ELEM_W'(acc) : base;
            chk("load_ready", DW'(load_ready), DW'(1));
            @(posedge clk);
            if (v) begin
                model[acc] = load_data;
                acc++;
            end
            #1;
            cyc++;
        end
        load_valid = 1'b0;
        chk("load_count", DW'(acc), DW'(nwords));
        if (nwords == DEPTH) begin
            chk("load_finish", DW'(finish), DW'(1));
            chk("load_busy_off", DW'(busy), DW'(0));
            chk("load_ready_off", DW'(load_ready), DW'(0));
            tick();
            chk("load_finish_pulse", DW'(finish), DW'(0));
        end
    endtask

    task automatic do_read(input bit stall, input bit check0);
        int n;
        int cyc;
        bit x;
        push_read();
        read_start = 1'b1;
        tick();
        read_start = 1'b0;
        chk("beat0_valid", DW'(out_valid), DW'(1));
        chk("read_busy", DW'(busy), DW'(1));
        if (check0)
            chk("beat0_data", out_data,
                128'h10000003_10000002_10000001_10000000);
        n = 0;
        cyc = 0;
        while (n < NBEATS && cyc < 200) begin
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            x = out_valid && out_ready;
            tick();
            if (x) n++;
            cyc++;
        end
        out_ready = 1'b0;
        chk("read_beats", DW'(n), DW'(NBEATS));
        if (!stall) chk("read_cycles", DW'(cyc), DW'(NBEATS));
        chk("read_finish", DW'(finish), DW'(1));
        chk("read_valid_off", DW'(out_valid), DW'(0));
        chk("read_last_off", DW'(out_last), DW'(0));
        chk("read_busy_off", DW'(busy), DW'(0));
        tick();
        chk("read_finish_pulse", DW'(finish), DW'(0));
    endtask

    // Monitor: one pop per accepted beat; stalled beats must hold
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stalled <= 1'b0;
        end else if (out_valid) begin
            if (stalled) chk("stall_hold", out_data, held);
            if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat got=%h", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", out_data, e.data);
                    chk("beat_last", DW'(out_last), DW'(e.last));
                end
                stalled <= 1'b0;
            end else begin
                stalled <= 1'b1;
                held    <= out_data;
            end
        end else begin
            stalled <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_load_ready", DW'(load_ready), DW'(0));
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_out_last", DW'(out_last), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_finish", DW'(finish), DW'(0));
        chk("rst_err", DW'(err), DW'(0));
        chk("rst_out_data", out_data, '0);
        rst = 1'b0;
        tick();

        do_load(32'h1000_0000, 1'b1, 1'b0, 1'b0, DEPTH);
        do_read(1'b0, 1'b1);
        do_read(1'b1, 1'b0);

        load_start = 1'b1;
        read_start = 1'b1;
        tick();
        load_start = 1'b0;
        read_start = 1'b0;
        chk("both_err", DW'(err), DW'(1));
        chk("both_load_wins", DW'(load_ready), DW'(1));
        chk("both_no_read", DW'(out_valid), DW'(0));
        tick();
        chk("both_err_pulse", DW'(err), DW'(0));
        read_start = 1'b1;
        tick();
        read_start = 1'b0;
        chk("busy_err", DW'(err), DW'(1));
        chk("busy_still_load", DW'(load_ready), DW'(1));
        tick();
        chk("busy_err_pulse", DW'(err), DW'(0));
        do_load(32'h2000_0000, 1'b1, 1'b0, 1'b1, DEPTH);
        do_read(1'b0, 1'b0);

        do_load(32'h3000_0000, 1'b1, 1'b1, 1'b0, DEPTH);
        do_read(1'b1, 1'b0);

        do_load(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", DW'(busy), DW'(0));
        chk("mid_rst_load_ready", DW'(load_ready), DW'(0));
        chk("mid_rst_finish", DW'(finish), DW'(0));
        chk("mid_rst_err", DW'(err), DW'(0));
        chk("mid_rst_out_valid", DW'(out_valid), DW'(0));
        chk("mid_rst_out_data", out_data, '0);
        tick();
        do_read(1'b0, 1'b0);

        chk("sb_empty", DW'(sb.size()), DW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
